// File: rtl/axi_wr_burst_monitor_if.sv
// AXI4 write-channel probe bundle: AW/W/B signals seen by a passive monitor.
// The monitor modport only observes; master/slave are the real bus endpoints.
interface axi_probe_intf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

  modport monitor (
    input awaddr, awlen, awvalid, awready, wlast, wvalid, wready,
    input bresp, bvalid, bready
  );
endinterface

// File: rtl/axi_wr_burst_monitor.sv
// Passive AXI4 write monitor: tracks outstanding AW, counts W beats against awlen,
// checks wlast placement and bresp; reports sticky errors and completion counters.
module axi_wr_burst_monitor #(
  parameter int ADDR_W   = 32,
  parameter int AW_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  axi_probe_intf.monitor    bus,
  input  logic              clear,
  output logic              burst_done,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [8:0]        burst_beats,
  output logic              err_wlast_early,
  output logic              err_wlast_late,
  output logic              err_w_no_aw,
  output logic              err_aw_ovf,
  output logic              err_b_orphan,
  output logic              err_bresp,
  output logic [CNT_W-1:0]  wr_done_cnt,
  output logic [3:0]        b_pending
);
  localparam int PTR_W = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
  localparam int CW    = PTR_W + 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_fifo_addr [AW_DEPTH];
  logic [7:0]          r_fifo_len  [AW_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]       r_count;
  logic [8:0]          r_beat_cnt, w_beat_nxt, w_beat_new, w_head_len1;
  logic                r_done;
  logic [ADDR_W-1:0]   r_burst_addr;
  logic [8:0]          r_burst_beats;
  logic [5:0]          r_err, w_err_set;
  logic [CNT_W-1:0]    r_wr_done;
  logic [3:0]          r_b_pending;

  logic w_aw_hs, w_w_hs, w_b_hs, w_empty, w_full;
  logic w_accept, w_close, w_push, w_b_ok;
  logic w_set_early, w_set_late, w_set_no_aw;

  assign w_aw_hs     = bus.awvalid & bus.awready;
  assign w_w_hs      = bus.wvalid & bus.wready;
  assign w_b_hs      = bus.bvalid & bus.bready;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(AW_DEPTH));
  assign w_head_len1 = {1'b0, r_fifo_len[r_rptr]} + 9'd1;
  assign w_beat_new  = r_beat_cnt + 9'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_accept    = 1'b0;
    w_close     = 1'b0;
    w_set_early = 1'b0;
    w_set_late  = 1'b0;
    w_set_no_aw = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_w_hs) begin
          if (w_empty) w_set_no_aw = 1'b1;
          else         w_accept    = 1'b1;
        end
      end
      S_BURST: w_accept = w_w_hs;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_accept) begin
      w_beat_nxt  = w_beat_new;
      w_state_nxt = S_BURST;
      // The final counted beat closes the burst even when wlast is missing.
      if (bus.wlast || (w_beat_new == w_head_len1)) begin
        w_close     = 1'b1;
        w_set_early = bus.wlast && (w_beat_new < w_head_len1);
        w_set_late  = !bus.wlast;
        w_beat_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    end
  end

  // A full FIFO still takes a new address when the head retires this cycle.
  assign w_push = w_aw_hs && (!w_full || w_close);
  // A B arriving with the closing beat pairs with that burst, not an orphan.
  assign w_b_ok = w_b_hs && ((r_b_pending != 4'd0) || w_close);

  assign w_err_set = {w_b_ok && (bus.bresp != 2'b00),
                      w_b_hs && !w_b_ok,
                      w_aw_hs && w_full && !w_close,
                      w_set_no_aw, w_set_late, w_set_early};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= bus.awaddr;
      r_fifo_len[r_wptr]  <= bus.awlen;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_beat_cnt    <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_burst_addr  <= '0;
      r_burst_beats <= '0;
      r_err         <= '0;
      r_wr_done     <= '0;
      r_b_pending   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_close) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_close);
      r_done  <= w_close;
      if (w_close) begin
        r_burst_addr  <= r_fifo_addr[r_rptr];
        r_burst_beats <= w_beat_new;
      end
      r_err <= (r_err & {6{~clear}}) | w_err_set;
      if (w_b_ok && (bus.bresp == 2'b00) && (r_wr_done != '1))
        r_wr_done <= r_wr_done + 1'b1;
      if (w_close && !w_b_ok && (r_b_pending != 4'hF))
        r_b_pending <= r_b_pending + 4'd1;
      else if (!w_close && w_b_ok)
        r_b_pending <= r_b_pending - 4'd1;
    end
  end

  assign burst_done      = r_done;
  assign burst_addr      = r_burst_addr;
  assign burst_beats     = r_burst_beats;
  assign err_wlast_early = r_err[0];
  assign err_wlast_late  = r_err[1];
  assign err_w_no_aw     = r_err[2];
  assign err_aw_ovf      = r_err[3];
  assign err_b_orphan    = r_err[4];
  assign err_bresp       = r_err[5];
  assign wr_done_cnt     = r_wr_done;
  assign b_pending       = r_b_pending;
endmodule
